geofence_feeder: RTL and testbench

- Upstream stage of the geofence point-in-hexagon checker.
- Buffers a point stream arriving over a valid/ready handshake in a FIFO. Replays each 7-point frame (target, then vertices V0..V5) onto the checker's free-running X/Y bus, exactly aligned to the checker's input window.
- Captures the checker's valid/is_inside result and re-issues it with a frame tag.
- Because the checker never stalls, any input window with fewer than 7 buffered points is filled with a dummy frame, and that frame's result is discarded.

---
 rtl/geofence_pkg.sv | 19 +
 rtl/geofence_pt_fifo.sv | 56 +++++
 rtl/geofence_feeder.sv | 149 ++++++++++++++
 tb/tb_geofence_feeder.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/geofence_pkg.sv
// Shared constants and types for the geofence feeder slice.
package geofence_pkg;

    localparam int unsigned COORD_W    = 10;
    localparam int unsigned FRAME_PTS  = 7;
    localparam int unsigned WINDOW_LEN = 8;

    typedef enum logic [1:0] {
        BOOT,
        SEND,
        WAIT
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } point_t;

endpackage

// File: rtl/geofence_pt_fifo.sv
// Synchronous point FIFO with first-word-fall-through head and occupancy count.
module geofence_pt_fifo
    import geofence_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  point_t                   push_pt,
    input  logic                     pop,
    output point_t                   head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    point_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && (count < CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_pt;
        end
    end

    // Pointers and count; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/geofence_feeder.sv
// Replays buffered 7-point frames onto the free-running checker bus and tags its results.
// Optional WAIT watchdog (wd_err port, TIMEOUT parameter): define GEOFENCE_FEEDER_WATCHDOG_EN.
module geofence_feeder
    import geofence_pkg::*;
#(
    parameter int unsigned DEPTH = 16
`ifdef GEOFENCE_FEEDER_WATCHDOG_EN
    , parameter int unsigned TIMEOUT = 63
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    output logic [COORD_W-1:0] X,
    output logic [COORD_W-1:0] Y,
    input  logic               gf_valid,
    input  logic               gf_inside,
    output logic               out_valid,
    output logic               out_inside,
    output logic [7:0]         out_frame_id,
    output logic [7:0]         dummy_cnt
`ifdef GEOFENCE_FEEDER_WATCHDOG_EN
    , output logic             wd_err
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    state_t             state;
    logic [2:0]         slot;
    logic               dummy;
    logic [7:0]         frame_id;
    logic [CNT_W-1:0]   fifo_count;
    point_t             fifo_head;
    point_t             in_pt;
    logic               real_avail;
    logic               start_frame;
    logic               pop;
    logic               wd_fire;

    assign in_pt      = {in_x, in_y};
    assign in_ready   = (fifo_count < CNT_W'(DEPTH));
    assign real_avail = (fifo_count >= CNT_W'(FRAME_PTS));

    geofence_pt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (in_valid),
        .push_pt (in_pt),
        .pop     (pop),
        .head    (fifo_head),
        .count   (fifo_count)
    );

    // X/Y are loaded on the edge entering each slot, so the pop is issued in the cycle before it.
    always_comb begin
        start_frame = 1'b0;
        pop         = 1'b0;
        case (state)
            BOOT:    start_frame = 1'b1;
            WAIT:    start_frame = gf_valid || wd_fire;
            default: start_frame = 1'b0;
        endcase
        if (start_frame) begin
            pop = real_avail;
        end else if (state == SEND && !dummy && slot < 3'(FRAME_PTS - 1)) begin
            pop = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= BOOT;
            slot         <= '0;
            dummy        <= 1'b0;
            X            <= '0;
            Y            <= '0;
            out_valid    <= 1'b0;
            out_inside   <= 1'b0;
            out_frame_id <= '0;
            frame_id     <= '0;
            dummy_cnt    <= '0;
        end else begin
            out_valid <= 1'b0;
            X         <= '0;
            Y         <= '0;
            if (state == WAIT && gf_valid && !dummy) begin
                out_valid    <= 1'b1;
                out_inside   <= gf_inside;
                out_frame_id <= frame_id;
                frame_id     <= frame_id + 8'd1;
            end
            if (start_frame) begin
                state <= SEND;
                slot  <= '0;
                dummy <= !real_avail;
                if (real_avail) begin
                    X <= fifo_head.x;
                    Y <= fifo_head.y;
                end else if (dummy_cnt != 8'hFF) begin
                    dummy_cnt <= dummy_cnt + 8'd1;
                end
            end else if (state == SEND) begin
                slot <= slot + 3'd1;
                if (pop) begin
                    X <= fifo_head.x;
                    Y <= fifo_head.y;
                end
                if (slot == 3'(WINDOW_LEN - 1)) begin
                    state <= WAIT;
                    slot  <= '0;
                end
            end
        end
    end

`ifdef GEOFENCE_FEEDER_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wait_cnt;

    assign wd_fire = (state == WAIT) && !gf_valid && (wait_cnt == WD_W'(TIMEOUT));

    // Counts WAIT cycles; a missing checker result forces a fresh window and latches the error.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= '0;
            wd_err   <= 1'b0;
        end else begin
            if (state == WAIT && !start_frame) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (wd_fire) begin
                wd_err <= 1'b1;
            end
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

endmodule

// File: tb/tb_geofence_feeder.sv
// Directed bench for geofence_feeder with a behavioural model of the checker's 8-cycle window.
module tb_geofence_feeder;

    localparam int CALC_LAT = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_x;
    logic [9:0] in_y;
    logic [9:0] X;
    logic [9:0] Y;
    logic       gf_valid;
    logic       gf_inside;
    logic       out_valid;
    logic       out_inside;
    logic [7:0] out_frame_id;
    logic [7:0] dummy_cnt;
`ifdef GEOFENCE_FEEDER_WATCHDOG_EN
    logic       wd_err;
`endif

    int checks   = 0;
    int failures = 0;

    logic [9:0] obs_x[$];
    logic [9:0] obs_y[$];
    logic       res_in[$];
    logic [7:0] res_id[$];
    int         n_win    = 0;
    int         dbl      = 0;
    bit         saw_full = 0;
    bit         hold     = 0;

    always #5 clk = ~clk;

    geofence_feeder dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .in_y         (in_y),
        .X            (X),
        .Y            (Y),
        .gf_valid     (gf_valid),
        .gf_inside    (gf_inside),
        .out_valid    (out_valid),
        .out_inside   (out_inside),
        .out_frame_id (out_frame_id),
        .dummy_cnt    (dummy_cnt)
`ifdef GEOFENCE_FEEDER_WATCHDOG_EN
        , .wd_err     (wd_err)
`endif
    );

    function automatic logic [9:0] px(input int k);
        return 10'(100 + k);
    endfunction

    function automatic logic [9:0] py(input int k);
        return 10'(900 - k);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Checker model: IDLE one cycle after reset, 8-cycle window, result CALC_LAT cycles later.
    initial begin : checker_model
        int   mode;
        int   pos;
        int   calc;
        logic rs;
        logic gv;
        logic prev_ov;
        logic [9:0] w_x0;
        mode = 0; pos = 0; calc = 0; prev_ov = 1'b0; w_x0 = '0;
        gf_valid = 1'b0;
        gf_inside = 1'b0;
        forever begin
            @(posedge clk);
            rs = reset;
            gv = gf_valid;
            #1;
            if (rs !== 1'b1) begin
                mode = 0;
                gf_valid = 1'b0;
                prev_ov = 1'b0;
                continue;
            end
            if (out_valid === 1'b1) begin
                res_in.push_back(out_inside);
                res_id.push_back(out_frame_id);
                if (prev_ov === 1'b1) dbl++;
            end
            prev_ov = out_valid;
            if (in_ready === 1'b0) saw_full = 1'b1;
            if (mode == 0) begin
                mode = 1;
                pos = 0;
            end else if (mode == 2) begin
                if (gv === 1'b1) begin
                    gf_valid = 1'b0;
                    mode = 1;
                    pos = 0;
                end else begin
                    calc++;
                    if (calc == CALC_LAT && !hold) begin
                        gf_valid = 1'b1;
                        gf_inside = w_x0[0];
                    end
                end
            end
            if (mode == 1) begin
                if (pos == 0) w_x0 = X;
                obs_x.push_back(X);
                obs_y.push_back(Y);
                pos++;
                if (pos == 8) begin
                    mode = 2;
                    calc = 0;
                    n_win++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_tb();
        obs_x.delete();
        obs_y.delete();
        res_in.delete();
        res_id.delete();
        n_win = 0;
        dbl = 0;
        saw_full = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        step();
        step();
        clear_tb();
    endtask

    task automatic push_n(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_x = px(base + i);
            in_y = py(base + i);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic release_push(input int n, input int base);
        reset = 1'b1;
        push_n(n, base);
    endtask

    task automatic wait_win(input string tag, input int n, input int budget);
        int cyc;
        cyc = 0;
        while (n_win < n && cyc < budget) begin
            step();
            cyc++;
        end
        check(tag, 32'(n_win >= n), 32'd1);
    endtask

    task automatic win_check(input string tag, input int w, input bit dummy, input int base);
        for (int s = 0; s < 8; s++) begin
            logic [19:0] exp;
            exp = (dummy || s == 7) ? 20'd0 : {px(base + s), py(base + s)};
            check($sformatf("%s_s%0d", tag, s), 32'({obs_x[w*8+s], obs_y[w*8+s]}), 32'(exp));
        end
    endtask

    initial begin : main
        int cyc;
        int n0;
        int k;
        int nreal;
        bit acc;
        reset = 1'b0;
        in_valid = 1'b0;
        in_x = '0;
        in_y = '0;

        // Reset state
        do_reset();
        check("rst_X", 32'(X), 32'd0);
        check("rst_Y", 32'(Y), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_inside", 32'(out_inside), 32'd0);
        check("rst_frame_id", 32'(out_frame_id), 32'd0);
        check("rst_dummy_cnt", 32'(dummy_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // 7 points from release: first window dummy, second replays them
        release_push(7, 0);
        wait_win("t1_wait", 2, 200);
        win_check("t1_w0", 0, 1'b1, 0);
        win_check("t1_w1", 1, 1'b0, 0);
        check("t1_dummy_cnt", 32'(dummy_cnt), 32'd1);
        wait_win("t1_wait3", 3, 200);
        check("t1_nres", 32'(res_in.size()), 32'd1);
        check("t1_id", 32'(res_id[0]), 32'd0);
        check("t1_inside", 32'(res_in[0]), 32'd0);

        // 14 points: two real frames, inside 1 then 0, ids 0 then 1
        do_reset();
        release_push(14, 21);
        wait_win("t2_wait", 4, 300);
        win_check("t2_w0", 0, 1'b1, 0);
        win_check("t2_w1", 1, 1'b0, 21);
        win_check("t2_w2", 2, 1'b0, 28);
        win_check("t2_w3", 3, 1'b1, 0);
        check("t2_nres", 32'(res_in.size()), 32'd2);
        check("t2_in0", 32'(res_in[0]), 32'd1);
        check("t2_id0", 32'(res_id[0]), 32'd0);
        check("t2_in1", 32'(res_in[1]), 32'd0);
        check("t2_id1", 32'(res_id[1]), 32'd1);
        check("t2_dummy_cnt", 32'(dummy_cnt), 32'd2);
        check("t2_pulse_width", 32'(dbl), 32'd0);

        // Reset at SEND slot 3 of a third real frame
        push_n(7, 40);
        cyc = 0;
        while (X !== px(43) && cyc < 200) begin
            step();
            cyc++;
        end
        check("t5_reach_slot3", 32'(X), 32'(px(43)));
        reset = 1'b0;
        step();
        check("t5_X", 32'(X), 32'd0);
        check("t5_Y", 32'(Y), 32'd0);
        check("t5_frame_id", 32'(out_frame_id), 32'd0);
        check("t5_dummy_cnt", 32'(dummy_cnt), 32'd0);
        check("t5_out_valid", 32'(out_valid), 32'd0);
        clear_tb();
        release_push(4, 51);
        step();
        step();
        step();
        push_n(3, 55);
        wait_win("t5_wait", 3, 200);
        win_check("t5_w0", 0, 1'b1, 0);
        win_check("t5_w1", 1, 1'b0, 51);
        check("t5_nres", 32'(res_in.size()), 32'd1);
        check("t5_id", 32'(res_id[0]), 32'd0);
        check("t5_inside", 32'(res_in[0]), 32'd1);

        // 6 points only: dummy windows forever, dummy_cnt saturates, count held at 6
        do_reset();
        release_push(6, 60);
        wait_win("t3_wait", 256, 4000);
        check("t3_dummy_sat", 32'(dummy_cnt), 32'd255);
        check("t3_nres", 32'(res_in.size()), 32'd0);
        n0 = n_win;
        push_n(1, 66);
        wait_win("t3_wait2", n0 + 3, 100);
        win_check("t3_real", n0, 1'b0, 60);
        win_check("t3_after", n0 + 1, 1'b1, 0);
        check("t3_dummy_hold", 32'(dummy_cnt), 32'd255);
        check("t3_nres2", 32'(res_in.size()), 32'd1);
        check("t3_id", 32'(res_id[0]), 32'd0);

        // Stream 42 points with in_valid held: FIFO fills, nothing lost or duplicated
        do_reset();
        reset = 1'b1;
        k = 0;
        cyc = 0;
        while (k < 42 && cyc < 2000) begin
            in_valid = 1'b1;
            in_x = px(70 + k);
            in_y = py(70 + k);
            acc = in_ready;
            step();
            cyc++;
            if (acc) k++;
        end
        in_valid = 1'b0;
        cyc = 0;
        while (res_in.size() < 6 && cyc < 1000) begin
            step();
            cyc++;
        end
        check("t4_nres", 32'(res_in.size()), 32'd6);
        check("t4_saw_full", 32'(saw_full), 32'd1);
        check("t4_in_ready_end", 32'(in_ready), 32'd1);
        nreal = 0;
        for (int w = 0; w < n_win; w++) begin
            if (obs_x[w*8] != 10'd0) begin
                win_check($sformatf("t4_f%0d", nreal), w, 1'b0, 70 + 7 * nreal);
                nreal++;
            end
        end
        check("t4_nreal", 32'(nreal), 32'd6);
        check("t4_last_id", 32'(res_id[5]), 32'd5);

`ifdef GEOFENCE_FEEDER_WATCHDOG_EN
        // Checker result withheld: watchdog fires on the 64th WAIT cycle and stays set
        do_reset();
        hold = 1'b1;
        reset = 1'b1;
        cyc = 0;
        while (wd_err !== 1'b1 && cyc < 300) begin
            step();
            cyc++;
        end
        check("wd_rise_cycle", 32'(cyc), 32'd73);
        check("wd_err_set", 32'(wd_err), 32'd1);
        check("wd_restart_dummy", 32'(dummy_cnt), 32'd2);
        for (int i = 0; i < 100; i++) step();
        check("wd_sticky", 32'(wd_err), 32'd1);
        do_reset();
        check("wd_cleared", 32'(wd_err), 32'd0);
        hold = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : global_guard
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
